// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory that accepts one load/store via valid/ready,
// waits LATENCY cycles, then commits the write or returns read data with a resp_valid pulse.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic                    r_wr;
    logic [ADDR_WIDTH-2:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [DATA_WIDTH-1:0]   r_mem [0:2**(ADDR_WIDTH-1)-1] = '{default: '0};
    logic                    w_commit;
    logic                    w_unused;

    // byte-address bit 0 never selects anything: storage is word-granular
    assign w_unused = req_addr[0];
    assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);

    always_comb begin
        w_next = (r_state == IDLE) ? (req_valid ? WAIT : IDLE) :
                 (r_state == WAIT) ? (w_commit ? RESP : WAIT) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_wr    <= req_wr;
                r_addr  <= req_addr[ADDR_WIDTH-1:1];
                r_wdata <= req_wdata;
                r_cnt   <= 4'(LATENCY - 1);
            end
            if (r_state == WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_commit && !r_wr)
                r_rdata <= r_mem[r_addr];
        end
    end

    // storage survives reset; a reset on the commit edge drops the pending write
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_wr)
            r_mem[r_addr] <= r_wdata;
    end

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign resp_rdata = r_rdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized transactions on a LATENCY=4 responder checked against
// a word-indexed associative-array memory model, plus a LATENCY=1 back-to-back instance.
module tb_data_mem_responder;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        v4, w4, v1, w1;
    logic [15:0] a4, d4, a1, d1;
    logic        r4, rv4, b4, r1, rv1, b1;
    logic [15:0] q4, q1;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model [int];
    logic [15:0] exp_rd;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LATENCY(LAT)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_wr(w4), .req_addr(a4), .req_wdata(d4),
        .req_ready(r4), .resp_valid(rv4), .resp_rdata(q4), .busy(b4));

    data_mem_responder #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_wr(w1), .req_addr(a1), .req_wdata(d1),
        .req_ready(r1), .resp_valid(rv1), .resp_rdata(q1), .busy(b1));

    function automatic logic [15:0] mrd(input logic [15:0] a);
        int idx = int'(a >> 1);
        return model.exists(idx) ? model[idx] : 16'h0000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // one full transaction on the LATENCY=4 instance; noise drives a write during WAIT/RESP
    task automatic xact(input logic wr, input logic [15:0] a, input logic [15:0] d, input bit noise);
        int n = 0;
        checks++;
        if (r4 !== 1'b1) begin errors++; $display("FAIL ready_idle got %b exp 1", r4); end
        v4 = 1'b1; w4 = wr; a4 = a; d4 = d;
        tick;
        if (noise) begin v4 = 1'b1; w4 = 1'b1; a4 = 16'h0020; d4 = 16'hDEAD; end
        else v4 = 1'b0;
        checks++;
        if (b4 !== 1'b1 || rv4 !== 1'b0) begin
            errors++; $display("FAIL busy_after_accept got busy=%b resp=%b exp 1/0", b4, rv4);
        end
        while (rv4 !== 1'b1 && n < 20) begin
            if (noise) begin
                checks++;
                if (r4 !== 1'b0) begin errors++; $display("FAIL ready_in_wait got %b exp 0", r4); end
            end
            tick;
            n++;
        end
        v4 = 1'b0;
        checks++;
        if (n !== LAT) begin errors++; $display("FAIL latency got %0d exp %0d", n, LAT); end
        if (wr) model[int'(a >> 1)] = d;
        else exp_rd = mrd(a);
        checks++;
        if (q4 !== exp_rd) begin
            errors++; $display("FAIL rdata wr=%b addr=%h got %h exp %h", wr, a, q4, exp_rd);
        end
        checks++;
        if (r4 !== 1'b0) begin errors++; $display("FAIL ready_in_resp got %b exp 0", r4); end
        tick;
        checks++;
        if (rv4 !== 1'b0 || r4 !== 1'b1 || b4 !== 1'b0) begin
            errors++; $display("FAIL back_to_idle got resp=%b ready=%b busy=%b exp 0/1/0", rv4, r4, b4);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; v4 = 1'b0; w4 = 1'b0; a4 = '0; d4 = '0;
        v1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0;
        tick;
        tick;
        rst = 1'b0;
        exp_rd = 16'h0000;
        checks++;
        if (r4 !== 1'b1 || rv4 !== 1'b0 || q4 !== 16'h0000 || b4 !== 1'b0) begin
            errors++; $display("FAIL reset4 got ready=%b resp=%b rdata=%h busy=%b exp 1/0/0000/0", r4, rv4, q4, b4);
        end
        checks++;
        if (r1 !== 1'b1 || rv1 !== 1'b0 || q1 !== 16'h0000 || b1 !== 1'b0) begin
            errors++; $display("FAIL reset1 got ready=%b resp=%b rdata=%h busy=%b exp 1/0/0000/0", r1, rv1, q1, b1);
        end
    endtask

    task automatic test_latency;
        xact(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        xact(1'b0, 16'h0010, 16'h0000, 1'b0);
    endtask

    task automatic test_addr;
        xact(1'b1, 16'hFFFE, 16'h1234, 1'b0);
        xact(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        xact(1'b0, 16'h0011, 16'h0000, 1'b0);
    endtask

    task automatic test_busy_ignore;
        xact(1'b1, 16'h0050, 16'h1111, 1'b1);
        xact(1'b0, 16'h0020, 16'h0000, 1'b0);
        xact(1'b0, 16'h0050, 16'h0000, 1'b0);
    endtask

    task automatic test_reset_mid;
        v4 = 1'b1; w4 = 1'b1; a4 = 16'h0030; d4 = 16'h5555;
        tick;
        v4 = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_rd = 16'h0000;
        checks++;
        if (b4 !== 1'b0 || r4 !== 1'b1) begin
            errors++; $display("FAIL rst_in_wait got busy=%b ready=%b exp 0/1", b4, r4);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rv4 !== 1'b0) begin errors++; $display("FAIL no_resp_after_rst got %b exp 0", rv4); end
            tick;
        end
        xact(1'b0, 16'h0030, 16'h0000, 1'b0);
        v4 = 1'b1; w4 = 1'b1; a4 = 16'h0060; d4 = 16'h7777;
        tick;
        v4 = 1'b0;
        repeat (LAT) tick;
        checks++;
        if (rv4 !== 1'b1) begin errors++; $display("FAIL resp_before_rst got %b exp 1", rv4); end
        model[int'(16'h0060 >> 1)] = 16'h7777;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_rd = 16'h0000;
        checks++;
        if (rv4 !== 1'b0 || r4 !== 1'b1) begin
            errors++; $display("FAIL rst_in_resp got resp=%b ready=%b exp 0/1", rv4, r4);
        end
        xact(1'b0, 16'h0060, 16'h0000, 1'b0);
        rst = 1'b1; v4 = 1'b1; w4 = 1'b1; a4 = 16'h0070; d4 = 16'h9999;
        tick;
        rst = 1'b0; v4 = 1'b0;
        checks++;
        if (b4 !== 1'b0) begin errors++; $display("FAIL rst_beats_valid got busy=%b exp 0", b4); end
        xact(1'b0, 16'h0070, 16'h0000, 1'b0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) begin
            logic [15:0] a = 16'h0100 + 16'($urandom_range(0, 15));
            xact(1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0);
        end
    endtask

    // LATENCY=1 with req_valid held: accept at cycle 0 mod 3, respond at cycle 2 mod 3
    task automatic test_back_to_back;
        logic [15:0] last = 16'h0000;
        logic        pend_wr = 1'b0;
        v1 = 1'b1; w1 = 1'b1; a1 = 16'h0040; d1 = 16'($urandom);
        for (int c = 0; c < 24; c++) begin
            logic acc;
            checks++;
            if (r1 !== (c % 3 == 0) || rv1 !== (c % 3 == 2)) begin
                errors++; $display("FAIL b2b_timing cyc=%0d got ready=%b resp=%b", c, r1, rv1);
            end
            if (rv1 === 1'b1 && !pend_wr) begin
                checks++;
                if (q1 !== last) begin errors++; $display("FAIL b2b_rdata got %h exp %h", q1, last); end
            end
            acc = r1;
            if (acc) begin
                pend_wr = w1;
                if (w1) last = d1;
            end
            tick;
            if (acc) begin w1 = ~w1; d1 = 16'($urandom); end
        end
        v1 = 1'b0;
        repeat (3) tick;
    endtask

    initial begin
        test_reset;
        test_latency;
        test_addr;
        test_busy_ignore;
        test_reset_mid;
        test_random;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
